// File: rtl/hold_debouncer.sv
// -----------------------------------------------------------------------------
// hold_debouncer
//
// Conditioning stage between a raw push-button and the 2-bit counter's hold_i.
// The button is asynchronous to clck_i and bounces, so it is first passed
// through a flip-flop synchroniser and then through a four-state debounce FSM.
// The FSM only accepts a new level after the synchronised button has held it
// for DEBOUNCE_CYCLES consecutive cycles. Every output is registered, so the
// counter never sees a metastable or chattering hold.
//
// Optional feature (compile-time macro HOLD_TOGGLE_EN):
//   defined   : hold_o toggles on every accepted press; releases leave it
//               alone (press once to freeze, press again to resume).
//   undefined : hold_o follows the debounced button level.
//   Ports, pulses and latency are the same in both builds.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a change (>=2)
//   SYNC_STAGES      flip-flops in the input synchroniser chain (>=2)
//
// Ports
//   clck_i           in   system clock, all logic on the rising edge
//   rst_i            in   asynchronous active-low reset
//   btn_i            in   raw button, asynchronous, may bounce
//   hold_o           out  debounced / toggled hold level for the counter
//   press_pulse_o    out  one-cycle pulse on an accepted 0->1
//   release_pulse_o  out  one-cycle pulse on an accepted 1->0
//
// Latency (bounce-free): a change first sampled at edge 1 produces its pulse
// after edge SYNC_STAGES + DEBOUNCE_CYCLES + 1.
// -----------------------------------------------------------------------------
module hold_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clck_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic hold_o,
  output logic press_pulse_o,
  output logic release_pulse_o
);

  // Width of the stability counter; never narrower than one bit.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // Terminal count: the cycle on which a pending change is accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Encoding keeps the debounced level in bit 1 (IDLE_HIGH / WAIT_LOW = 1x).
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b11,
    WAIT_LOW  = 2'b10
  } state_t;

  // Synchroniser chain; index SYNC_STAGES-1 is the stage the FSM uses.
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   btn_s;

  // FSM state and stability counter.
  state_t                 state_r;
  state_t                 state_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_s;

  // Registered outputs and their next values.
  logic                   press_r;
  logic                   press_s;
  logic                   release_r;
  logic                   release_s;
  logic                   hold_r;
  logic                   hold_s;

  assign btn_s = sync_r[SYNC_STAGES-1];

  // Input synchroniser: shift the raw button through SYNC_STAGES flops.
  always_ff @(posedge clck_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], btn_i};
    end
  end

  // Debounce FSM state and counter registers.
  always_ff @(posedge clck_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE_LOW;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state, counter and pulse decode. The counter defaults to zero so it
  // is held at 0 in both idle states and restarts whenever a wait is aborted.
  always_comb begin
    state_s   = state_r;
    cnt_s     = '0;
    press_s   = 1'b0;
    release_s = 1'b0;
    case (state_r)
      IDLE_LOW: begin
        if (btn_s) begin
          state_s = WAIT_HIGH;
        end else begin
          state_s = IDLE_LOW;
        end
      end
      WAIT_HIGH: begin
        if (!btn_s) begin
          // Bounce: discard and start over from the low idle state.
          state_s = IDLE_LOW;
        end else if (cnt_r >= CNT_MAX) begin
          // >= rather than == so a corrupted counter accepts instead of wrapping.
          state_s = IDLE_HIGH;
          press_s = 1'b1;
        end else begin
          state_s = WAIT_HIGH;
          cnt_s   = cnt_r + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!btn_s) begin
          state_s = WAIT_LOW;
        end else begin
          state_s = IDLE_HIGH;
        end
      end
      WAIT_LOW: begin
        if (btn_s) begin
          state_s = IDLE_HIGH;
        end else if (cnt_r >= CNT_MAX) begin
          state_s   = IDLE_LOW;
          release_s = 1'b1;
        end else begin
          state_s = WAIT_LOW;
          cnt_s   = cnt_r + 1'b1;
        end
      end
      default: begin
        // Unreachable encoding: fall back to the safe, released state.
        state_s = IDLE_LOW;
      end
    endcase
  end

  // Next hold level, changing on the same edge that raises a pulse.
  always_comb begin
    hold_s = hold_r;
`ifdef HOLD_TOGGLE_EN
    if (press_s) begin
      hold_s = ~hold_r;
    end else begin
      hold_s = hold_r;
    end
`else
    // Bit 1 of the encoding is the debounced level.
    if (state_s[1]) begin
      hold_s = 1'b1;
    end else begin
      hold_s = 1'b0;
    end
`endif
  end

  // Output registers; pulses are high for exactly the cycle after acceptance.
  always_ff @(posedge clck_i or negedge rst_i) begin
    if (!rst_i) begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
      hold_r    <= 1'b0;
    end else begin
      press_r   <= press_s;
      release_r <= release_s;
      hold_r    <= hold_s;
    end
  end

  assign hold_o          = hold_r;
  assign press_pulse_o   = press_r;
  assign release_pulse_o = release_r;

endmodule
